// File: rtl/seq_pkg.sv
// Shared state encoding and default timing constants for the phase sequencer.
package seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DEF_CNT_W  = 6;
  localparam int DEF_NUM_PH = 5;
  localparam int DEF_PERIOD = 63;

  // Phase 0 sits in the least significant slice.
  localparam logic [DEF_NUM_PH*DEF_CNT_W-1:0] DEF_TAPS =
    {6'd40, 6'd30, 6'd20, 6'd10, 6'd5};

endpackage

// File: rtl/phase_tap.sv
// One registered phase strobe: fires one cycle after the counter matches TAP
// while the sequencer is actively counting.
module phase_tap
  import seq_pkg::*;
#(
  parameter int               CNT_W  = DEF_CNT_W,
  parameter logic [CNT_W-1:0] TAP    = '0,
  parameter int               PERIOD = DEF_PERIOD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fire_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             strobe_o
);

  // A tap beyond the end of the sequence is unreachable and stays silent.
  localparam bit TAP_LIVE = (int'(TAP) <= PERIOD);

  logic hit_p0;
  logic strobe_p1;

  always_comb begin
    hit_p0 = TAP_LIVE && fire_i && (cnt_i == TAP);
  end

  // p0 -> p1: compare result registered into the strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_p1 <= 1'b0;
    end else begin
      strobe_p1 <= hit_p0;
    end
  end

  assign strobe_o = strobe_p1;

endmodule

// File: rtl/phase_sequencer.sv
// Phase sequencer: counts 0..PERIOD in RUN and emits registered per-phase
// strobes at programmable taps, one-shot or free-running.
module phase_sequencer
  import seq_pkg::*;
#(
  parameter int                      CNT_W  = DEF_CNT_W,
  parameter int                      NUM_PH = DEF_NUM_PH,
  parameter int                      PERIOD = DEF_PERIOD,
  parameter logic [NUM_PH*CNT_W-1:0] TAPS   = DEF_TAPS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              en_i,
  input  logic              repeat_i,
  output logic [NUM_PH-1:0] phase_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              busy_o,
  output logic              done_o
);

  generate
    if (NUM_PH < 1 || PERIOD < 1 || PERIOD > (1 << CNT_W) - 1) begin : g_param_err
      $error("phase_sequencer: illegal CNT_W/NUM_PH/PERIOD combination");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD);

  state_e           state_p0, state_d;
  logic [CNT_W-1:0] cnt_p0, cnt_d;
  logic             done_p1, done_d;
  logic             fire_p0;

  // p0: state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= ST_IDLE;
      cnt_p0   <= '0;
      done_p1  <= 1'b0;
    end else begin
      state_p0 <= state_d;
      cnt_p0   <= cnt_d;
      done_p1  <= done_d;
    end
  end

  // Start overrides everything, including the end-of-sequence decision.
  always_comb begin
    state_d = state_p0;
    cnt_d   = cnt_p0;
    if (start_i) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else if (state_p0 == ST_RUN && en_i) begin
      if (cnt_p0 == LAST) begin
        if (repeat_i) begin
          cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        cnt_d = cnt_p0 + CNT_W'(1);
      end
    end
  end

  always_comb begin
    fire_p0 = (state_p0 == ST_RUN) && en_i && !start_i;
    done_d  = fire_p0 && (cnt_p0 == LAST) && !repeat_i;
  end

  // p0 -> p1: per-phase tap compares
  for (genvar i = 0; i < NUM_PH; i++) begin : g_tap
    phase_tap #(
      .CNT_W  (CNT_W),
      .TAP    (TAPS[i*CNT_W +: CNT_W]),
      .PERIOD (PERIOD)
    ) u_tap (
      .clk      (clk),
      .rst_n    (rst_n),
      .fire_i   (fire_p0),
      .cnt_i    (cnt_p0),
      .strobe_o (phase_o[i])
    );
  end

  assign busy_o = (state_p0 == ST_RUN);
  assign cnt_o  = cnt_p0;
  assign done_o = done_p1;

endmodule
